// File: rtl/vad_frame_ctrl.sv
// vad_frame_ctrl: frames the incoming PCM stream into energy-accumulator
// windows and runs a voice-activity detector on the resulting frame energies.
//
// Optional feature: define VAD_NOISE_TRACK_EN to let silent frames keep
// adapting the noise floor after initialisation. Without it the noise floor
// is frozen once the initial average is taken until the next start.
//
// Two FSMs:
//   frame FSM (F_IDLE/F_RUN/F_GAP) - drives pa_en/pa_data, catches pa_finish,
//                                    aborts on a missing sample or timeout.
//   VAD FSM   (V_IDLE..V_HANG)     - averages the noise floor, then tracks
//                                    speech segments with a hang-over count.

module vad_frame_ctrl #(
    parameter int unsigned FRAME_LEN   = 1024,
    parameter int unsigned INIT_FRAMES = 8,
    parameter int unsigned HANG_FRAMES = 4,
    parameter int unsigned THR_SHIFT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        sample_valid,
    input  logic [15:0] sample_in,
    output logic        pa_en,
    output logic [15:0] pa_data,
    input  logic [25:0] pa_sum,
    input  logic        pa_finish,
    output logic        vad_active,
    output logic        seg_start,
    output logic        seg_end,
    output logic        frame_done,
    output logic [25:0] noise_floor,
    output logic [25:0] frame_energy,
    output logic        err_timeout,
    output logic        busy
);

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned ENERGY_W   = 26;
    localparam int unsigned ACC_W      = 29;
    localparam int unsigned THR_W      = 31;
    localparam int unsigned CNT_W      = 11;
    localparam int unsigned HANG_W     = 4;
    localparam int unsigned INIT_LOG2  = $clog2(INIT_FRAMES);
    localparam int unsigned INIT_CNT_W = INIT_LOG2 + 1;

    // Cycle count at which a frame without pa_finish is declared dead.
    localparam logic [CNT_W-1:0]      TIMEOUT_CNT = CNT_W'(FRAME_LEN + 8);
    localparam logic [INIT_CNT_W-1:0] INIT_LAST   = INIT_CNT_W'(INIT_FRAMES - 1);
    localparam logic [HANG_W-1:0]     HANG_LOAD   = HANG_W'(HANG_FRAMES - 1);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_RUN  = 2'd1,
        F_GAP  = 2'd2
    } fstate_t;

    typedef enum logic [2:0] {
        V_IDLE   = 3'd0,
        V_INIT   = 3'd1,
        V_SIL    = 3'd2,
        V_SPEECH = 3'd3,
        V_HANG   = 3'd4
    } vstate_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    fstate_t                r_fstate;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pa_en;
    logic [SAMPLE_W-1:0]    r_pa_data;
    logic                   r_frame_done;
    logic [ENERGY_W-1:0]    r_frame_energy;
    logic                   r_err_timeout;

    vstate_t                r_vstate;
    logic [ACC_W-1:0]       r_init_acc;
    logic [INIT_CNT_W-1:0]  r_init_cnt;
    logic [HANG_W-1:0]      r_hang_cnt;
    logic [ENERGY_W-1:0]    r_noise_floor;
    logic                   r_seg_start;
    logic                   r_seg_end;
    logic                   r_vad_active;
    logic                   r_busy;

    // ------------------------------------------------------------------
    // Combinational next-state wires
    // ------------------------------------------------------------------
    fstate_t                w_fnext;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_fd_nxt;
    logic [ENERGY_W-1:0]    w_energy_nxt;
    logic                   w_tmo_set;
    logic                   w_vad_on;
    logic                   w_start_acc;

    vstate_t                w_vnext;
    logic [ACC_W-1:0]       w_acc_sum;
    logic [ACC_W-1:0]       w_acc_nxt;
    logic [INIT_CNT_W-1:0]  w_icnt_nxt;
    logic [HANG_W-1:0]      w_hang_nxt;
    logic [ENERGY_W-1:0]    w_nf_nxt;
    logic [THR_W-1:0]       w_thr;
    logic                   w_loud;
    logic                   w_ss_nxt;
    logic                   w_se_nxt;
`ifdef VAD_NOISE_TRACK_EN
    logic [ENERGY_W-1:0]    w_nf_track;
`endif

    // Framing only runs while the detector is armed; start is only honoured from idle.
    assign w_vad_on    = (r_vstate != V_IDLE);
    assign w_start_acc = start && !stop && (r_vstate == V_IDLE);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------

    // Frame FSM next state: run, capture energy, abort on gap/timeout.
    always_comb begin
        w_fnext      = r_fstate;
        w_cnt_inc    = r_cnt + CNT_W'(1);
        w_cnt_nxt    = '0;
        w_fd_nxt     = 1'b0;
        w_energy_nxt = r_frame_energy;
        w_tmo_set    = 1'b0;

        case (r_fstate)
            F_IDLE: begin
                if (w_vad_on && sample_valid) begin
                    w_fnext = F_RUN;
                end
            end
            F_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                if (pa_finish) begin
                    w_energy_nxt = pa_sum;
                    w_fd_nxt     = 1'b1;
                    w_cnt_nxt    = '0;
                    w_fnext      = F_GAP;
                end else if (!sample_valid) begin
                    w_cnt_nxt = '0;
                    w_fnext   = F_GAP;
                end else if (w_cnt_inc == TIMEOUT_CNT) begin
                    w_tmo_set = 1'b1;
                    w_cnt_nxt = '0;
                    w_fnext   = F_GAP;
                end
            end
            F_GAP: begin
                // One cycle with pa_en low lets the accumulator clear.
                w_fnext = (w_vad_on && sample_valid) ? F_RUN : F_IDLE;
            end
            default: begin
                w_fnext = F_IDLE;
            end
        endcase

        // stop overrides everything, including a coincident pa_finish.
        if (stop) begin
            w_fnext      = F_IDLE;
            w_cnt_nxt    = '0;
            w_fd_nxt     = 1'b0;
            w_energy_nxt = r_frame_energy;
            w_tmo_set    = 1'b0;
        end
    end

    // Frame FSM state and registered accumulator-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fstate       <= F_IDLE;
            r_cnt          <= '0;
            r_pa_en        <= 1'b0;
            r_pa_data      <= '0;
            r_frame_done   <= 1'b0;
            r_frame_energy <= '0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_fstate       <= w_fnext;
            r_cnt          <= w_cnt_nxt;
            r_pa_en        <= (w_fnext == F_RUN);
            r_pa_data      <= (w_fnext == F_RUN) ? sample_in : '0;
            r_frame_done   <= w_fd_nxt;
            r_frame_energy <= w_energy_nxt;
            r_err_timeout  <= w_tmo_set || (r_err_timeout && !w_start_acc);
        end
    end

    // ------------------------------------------------------------------
    // VAD FSM
    // ------------------------------------------------------------------

    // Threshold and noise-floor arithmetic on the latest captured frame.
    always_comb begin
        w_acc_sum = r_init_acc + ACC_W'(r_frame_energy);
        w_thr     = THR_W'(r_noise_floor) << THR_SHIFT;
        w_loud    = (THR_W'(r_frame_energy) > w_thr);
`ifdef VAD_NOISE_TRACK_EN
        w_nf_track = r_noise_floor - (r_noise_floor >> 4) + (r_frame_energy >> 4);
`endif
    end

    // VAD FSM next state: noise-floor init, speech detection, hang-over.
    always_comb begin
        w_vnext    = r_vstate;
        w_acc_nxt  = r_init_acc;
        w_icnt_nxt = r_init_cnt;
        w_hang_nxt = r_hang_cnt;
        w_nf_nxt   = r_noise_floor;
        w_ss_nxt   = 1'b0;
        w_se_nxt   = 1'b0;

        case (r_vstate)
            V_IDLE: begin
                if (start) begin
                    w_vnext    = V_INIT;
                    w_acc_nxt  = '0;
                    w_icnt_nxt = '0;
                end
            end
            V_INIT: begin
                if (r_frame_done) begin
                    w_acc_nxt  = w_acc_sum;
                    w_icnt_nxt = r_init_cnt + INIT_CNT_W'(1);
                    if (r_init_cnt == INIT_LAST) begin
                        w_nf_nxt = ENERGY_W'(w_acc_sum >> INIT_LOG2);
                        w_vnext  = V_SIL;
                    end
                end
            end
            V_SIL: begin
                if (r_frame_done) begin
                    if (w_loud) begin
                        w_vnext  = V_SPEECH;
                        w_ss_nxt = 1'b1;
                    end
`ifdef VAD_NOISE_TRACK_EN
                    else begin
                        w_nf_nxt = w_nf_track;
                    end
`endif
                end
            end
            V_SPEECH: begin
                if (r_frame_done && !w_loud) begin
                    w_vnext    = V_HANG;
                    w_hang_nxt = HANG_LOAD;
                end
            end
            V_HANG: begin
                if (r_frame_done) begin
                    if (w_loud) begin
                        w_vnext = V_SPEECH;
                    end else if (r_hang_cnt == '0) begin
                        w_vnext  = V_SIL;
                        w_se_nxt = 1'b1;
                    end else begin
                        w_hang_nxt = r_hang_cnt - HANG_W'(1);
                    end
                end
            end
            default: begin
                w_vnext = V_IDLE;
            end
        endcase

        // stop wins over start; an open segment is closed with seg_end.
        if (stop) begin
            w_vnext  = V_IDLE;
            w_nf_nxt = r_noise_floor;
            w_ss_nxt = 1'b0;
            w_se_nxt = r_vad_active;
        end
    end

    // VAD FSM state, noise floor and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vstate      <= V_IDLE;
            r_init_acc    <= '0;
            r_init_cnt    <= '0;
            r_hang_cnt    <= '0;
            r_noise_floor <= '0;
            r_seg_start   <= 1'b0;
            r_seg_end     <= 1'b0;
            r_vad_active  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_vstate      <= w_vnext;
            r_init_acc    <= w_acc_nxt;
            r_init_cnt    <= w_icnt_nxt;
            r_hang_cnt    <= w_hang_nxt;
            r_noise_floor <= w_nf_nxt;
            r_seg_start   <= w_ss_nxt;
            r_seg_end     <= w_se_nxt;
            r_vad_active  <= (w_vnext == V_SPEECH) || (w_vnext == V_HANG);
            r_busy        <= (w_vnext != V_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pa_en        = r_pa_en;
    assign pa_data      = r_pa_data;
    assign frame_done   = r_frame_done;
    assign frame_energy = r_frame_energy;
    assign err_timeout  = r_err_timeout;
    assign noise_floor  = r_noise_floor;
    assign seg_start    = r_seg_start;
    assign seg_end      = r_seg_end;
    assign vad_active   = r_vad_active;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vad_frame_ctrl.sv
// Bench for vad_frame_ctrl: a reference model of the VAD rules predicts, per
// issued frame, the energy, segment pulses, activity and noise floor; a
// monitor pops those predictions whenever the DUT reports frame_done.
// Build with VAD_NOISE_TRACK_EN defined to exercise noise tracking.

module tb_vad_frame_ctrl;

    localparam int INIT_F  = 8;
    localparam int HANG_F  = 4;
    localparam int SHIFT   = 2;
    localparam int FLEN    = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        pa_en;
    logic [15:0] pa_data;
    logic [25:0] pa_sum;
    logic        pa_finish;
    logic        vad_active;
    logic        seg_start;
    logic        seg_end;
    logic        frame_done;
    logic [25:0] noise_floor;
    logic [25:0] frame_energy;
    logic        err_timeout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    vad_frame_ctrl #(
        .FRAME_LEN  (FLEN),
        .INIT_FRAMES(INIT_F),
        .HANG_FRAMES(HANG_F),
        .THR_SHIFT  (SHIFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .pa_en       (pa_en),
        .pa_data     (pa_data),
        .pa_sum      (pa_sum),
        .pa_finish   (pa_finish),
        .vad_active  (vad_active),
        .seg_start   (seg_start),
        .seg_end     (seg_end),
        .frame_done  (frame_done),
        .noise_floor (noise_floor),
        .frame_energy(frame_energy),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint e;
        bit     ss;
        bit     se;
        bit     va;
        longint nf;
    } exp_t;

    exp_t   q[$];
    longint m_nf       = 0;
    longint m_init_sum = 0;
    int     m_init_n   = 0;
    bit     m_in_seg   = 0;
    int     m_quiet    = 0;

    function automatic longint m_thr();
        return m_nf * (64'd1 << SHIFT);
    endfunction

    task automatic model_start();
        m_init_sum = 0;
        m_init_n   = 0;
        m_in_seg   = 0;
        m_quiet    = 0;
    endtask

    task automatic model_stop();
        m_in_seg = 0;
        m_quiet  = 0;
    endtask

    // A segment opens on a frame above threshold and closes after HANG_F+1
    // consecutive frames at or below it.
    task automatic model_frame(input longint e);
        exp_t x;
        x.e  = e;
        x.ss = 0;
        x.se = 0;
        if (m_init_n < INIT_F) begin
            m_init_sum += e;
            m_init_n++;
            if (m_init_n == INIT_F) m_nf = m_init_sum / INIT_F;
        end else if (!m_in_seg) begin
            if (e > m_thr()) begin
                m_in_seg = 1;
                m_quiet  = 0;
                x.ss     = 1;
            end else begin
`ifdef VAD_NOISE_TRACK_EN
                m_nf = m_nf - m_nf / 16 + e / 16;
`endif
            end
        end else begin
            if (e > m_thr()) begin
                m_quiet = 0;
            end else begin
                m_quiet++;
                if (m_quiet == HANG_F + 1) begin
                    m_in_seg = 0;
                    x.se     = 1;
                end
            end
        end
        x.va = m_in_seg;
        x.nf = m_nf;
        q.push_back(x);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pa_en(input string nm);
        int guard = 0;
        while (!pa_en && guard < 50) begin
            tick();
            guard++;
        end
        if (!pa_en) chk(nm, 32'(pa_en), 1);
    endtask

    // One complete frame finished by the accumulator with energy e.
    task automatic do_frame(input longint e);
        sample_valid = 1'b1;
        wait_pa_en("frame_pa_en_start");
        repeat ($urandom_range(8, 40)) tick();
        pa_sum    = 26'(e);
        pa_finish = 1'b1;
        model_frame(e);
        tick();
        pa_finish = 1'b0;
        pa_sum    = 26'($urandom);
    endtask

    // Free-running random sample stream.
    initial begin
        sample_in = '0;
        forever begin
            @(posedge clk);
            #1;
            sample_in = 16'($urandom);
        end
    end

    // pa_data must be the sample present one edge earlier.
    logic [15:0] last_sample;
    always @(posedge clk) last_sample <= sample_in;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && pa_en) chk("pa_data_latency", 32'(pa_data), 32'(last_sample));
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n && frame_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame_done", 32'(frame_done), 0);
                end else begin
                    x = q.pop_front();
                    chk("frame_energy", 32'(frame_energy), 32'(x.e));
                    @(negedge clk);
                    chk("seg_start", 32'(seg_start), 32'(x.ss));
                    chk("seg_end", 32'(seg_end), 32'(x.se));
                    chk("vad_active", 32'(vad_active), 32'(x.va));
                    chk("noise_floor", 32'(noise_floor), 32'(x.nf));
                    @(negedge clk);
                    chk("seg_pulse_width", 32'({seg_start, seg_end}), 0);
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int  cnt;
        bit  seen;
        longint e;

        rst_n        = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        sample_valid = 1'b0;
        pa_sum       = '0;
        pa_finish    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_pa_en", 32'(pa_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vad_active", 32'(vad_active), 0);
        chk("rst_noise_floor", 32'(noise_floor), 0);
        chk("rst_frame_energy", 32'(frame_energy), 0);
        chk("rst_err_timeout", 32'(err_timeout), 0);
        chk("rst_pulses", 32'({seg_start, seg_end, frame_done}), 0);

        // Samples while idle must not reach the accumulator.
        rst_n        = 1'b1;
        sample_valid = 1'b1;
        repeat (5) tick();
        chk("idle_no_pa_en", 32'(pa_en), 0);
        chk("idle_busy", 32'(busy), 0);

        // Noise floor initialisation from eight 1000 frames.
        model_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("start_busy", 32'(busy), 1);
        for (int i = 0; i < INIT_F; i++) do_frame(1000);
        repeat (3) tick();
        chk("init_noise_floor", 32'(noise_floor), 1000);
        chk("init_silent", 32'(vad_active), 0);

        // Silent frame of 200.
        do_frame(200);
        repeat (3) tick();
`ifdef VAD_NOISE_TRACK_EN
        chk("track_noise_floor", 32'(noise_floor), 950);
`else
        chk("frozen_noise_floor", 32'(noise_floor), 1000);
`endif

        // Energy exactly at threshold stays silent; 5000 opens a segment.
        do_frame(m_thr());
        do_frame(5000);
        repeat (3) tick();
        chk("speech_active", 32'(vad_active), 1);

        // Hang-over: a loud third frame cancels the countdown, then a full quiet run ends it.
        do_frame(100);
        do_frame(100);
        do_frame(5000);
        for (int i = 0; i < HANG_F + 1; i++) do_frame(100);
        repeat (3) tick();
        chk("hang_closed", 32'(vad_active), 0);

        // sample_valid drop at cycle 500 of a frame.
        sample_valid = 1'b1;
        wait_pa_en("abort_pa_en_start");
        repeat (499) tick();
        sample_valid = 1'b0;
        tick();
        chk("abort_pa_en_low", 32'(pa_en), 0);
        chk("abort_no_frame_done", 32'(frame_done), 0);
        sample_valid = 1'b1;
        tick();
        chk("abort_pa_en_back", 32'(pa_en), 1);
        do_frame(100);
        repeat (3) tick();

        // Timeout with pa_finish never asserted.
        sample_valid = 1'b0;
        repeat (3) tick();
        chk("pre_timeout_clear", 32'(err_timeout), 0);
        sample_valid = 1'b1;
        cnt  = 0;
        seen = 0;
        for (int i = 0; i < 1200 && !seen; i++) begin
            @(negedge clk);
            if (err_timeout) seen = 1;
            else if (pa_en) cnt++;
        end
        chk("timeout_seen", 32'(seen), 1);
        chk("timeout_cycles", 32'(cnt), 1032);
        sample_valid = 1'b0;
        repeat (3) tick();
        chk("timeout_sticky", 32'(err_timeout), 1);

        // start while running is ignored and does not clear the error.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("start_ignored_err", 32'(err_timeout), 1);
        chk("start_ignored_busy", 32'(busy), 1);

        // stop (with start) during speech.
        do_frame(m_thr() + 1000);
        repeat (5) tick();
        chk("pre_stop_active", 32'(vad_active), 1);
        chk("pre_stop_running", 32'(pa_en), 1);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        model_stop();
        chk("stop_seg_end", 32'(seg_end), 1);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_vad_active", 32'(vad_active), 0);
        chk("stop_pa_en", 32'(pa_en), 0);
        chk("stop_nf_kept", 32'(noise_floor), 32'(m_nf));
        tick();
        chk("stop_seg_end_pulse", 32'(seg_end), 0);
        chk("stop_beats_start", 32'(busy), 0);

        // Restart clears the error; random init and random frames.
        model_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_err_clear", 32'(err_timeout), 0);
        chk("restart_busy", 32'(busy), 1);
        for (int i = 0; i < INIT_F; i++) do_frame(longint'($urandom_range(500, 3000)));
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       e = m_thr();
                1:       e = m_thr() + 1;
                2:       e = longint'($urandom_range(0, 32'(m_thr())));
                default: e = m_thr() + 1 + longint'($urandom_range(0, 32'(m_thr())));
            endcase
            do_frame(e);
        end
        repeat (4) tick();
        chk("scoreboard_drained", 32'(q.size()), 0);

        // Asynchronous reset in the middle of a frame.
        chk("pre_reset_running", 32'(pa_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pa_en", 32'(pa_en), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_nf", 32'(noise_floor), 0);
        chk("async_rst_energy", 32'(frame_energy), 0);
        sample_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
